// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer.
// Holds the state encoding, MODE codes and the coil phase table.
package stepper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    // Index 0 is the leftmost entry; bit order is {O_3,O_2,O_1,O_0}.
    localparam logic [0:7][3:0] PHASE_TABLE = {
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    function automatic logic [2:0] step_size(input logic [1:0] mode);
        return (mode == MODE_HALF) ? 3'd1 : 3'd2;
    endfunction

    // Wave uses even table entries, full uses odd ones, half uses all.
    function automatic logic [2:0] align_pos(input logic [1:0] mode,
                                             input logic [2:0] pos);
        logic [2:0] r;
        unique case (mode)
            MODE_FULL: r = {pos[2:1], 1'b1};
            MODE_HALF: r = pos;
            default:   r = {pos[2:1], 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stepper_if.sv
// Command and drive signals between a move controller and the sequencer.
// The controller side is master, the sequencer side is slave.
interface stepper_if #(
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
);
    logic              START;
    logic              ABORT;
    logic              DIR;
    logic [1:0]        MODE;
    logic [STEP_W-1:0] STEPS;
    logic [DIV_W-1:0]  DIV;
    logic              O_0;
    logic              O_1;
    logic              O_2;
    logic              O_3;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, ABORT, DIR, MODE, STEPS, DIV,
        input  O_0, O_1, O_2, O_3, BUSY, DONE
    );

    modport slave (
        input  START, ABORT, DIR, MODE, STEPS, DIV,
        output O_0, O_1, O_2, O_3, BUSY, DONE
    );
endinterface

// File: rtl/stepper_prescaler.sv
// Step-period down-counter: loads DIV, ticks at zero, reloads.
// The tick is high during the cycle whose closing edge applies a step.
module stepper_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] reload;

    assign tick = en && (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= div;
            reload <= div;
        end else if (tick) begin
            count <= reload;
        end else if (en) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor phase sequencer with wave, full and half stepping.
// Moves are latched at START and paced by the prescaler tick.
module stepper_sequencer #(
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input logic       CLK,
    input logic       RST,
    stepper_if.slave  bus
);
    import stepper_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [2:0]        pos;
    logic [STEP_W-1:0] remaining;
    logic              dir;
    logic [1:0]        mode;
    logic              done;
    logic              done_next;
    logic              load;
    logic              align;
    logic              step;
    logic              tick;

    stepper_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (CLK),
        .rst  (RST),
        .load (load),
        .en   (state == RUN),
        .div  (bus.DIV),
        .tick (tick)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        align      = 1'b0;
        step       = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    align = 1'b1;
                    if (bus.STEPS != '0) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coincident tick: no step, no DONE.
                if (bus.ABORT) begin
                    state_next = IDLE;
                end else if (tick) begin
                    step = 1'b1;
                    if (remaining == STEP_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            remaining <= '0;
            dir       <= 1'b0;
            mode      <= MODE_WAVE;
        end else if (load) begin
            remaining <= bus.STEPS;
            dir       <= bus.DIR;
            mode      <= bus.MODE;
        end else if (step) begin
            remaining <= remaining - 1'b1;
        end
    end

    // 3-bit arithmetic gives the modulo-8 wrap in both directions.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos <= 3'd0;
        end else if (align) begin
            pos <= align_pos(bus.MODE, pos);
        end else if (step) begin
            pos <= dir ? pos - step_size(mode)
                       : pos + step_size(mode);
        end
    end

    assign {bus.O_3, bus.O_2, bus.O_1, bus.O_0} = PHASE_TABLE[pos];
    assign bus.BUSY = (state == RUN);
    assign bus.DONE = done;
endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer.
// Expected phases and handshake timing are hand-computed per step.
module tb_stepper_sequencer;
    import stepper_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stepper_if #(.STEP_W(8), .DIV_W(8)) bus ();

    stepper_sequencer #(.STEP_W(8), .DIV_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {bus.O_3, bus.O_2, bus.O_1, bus.O_0};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] m, input logic d,
                      input logic [7:0] s, input logic [7:0] v);
        bus.MODE  = m;
        bus.DIR   = d;
        bus.STEPS = s;
        bus.DIV   = v;
        bus.START = 1'b1;
    endtask

    logic [3:0] h_out [1:9];
    logic [3:0] w_out [1:5];

    initial begin
        h_out = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011,
                  4'b0010, 4'b0010, 4'b0010, 4'b0110};
        w_out = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.DIR   = 1'b0;
        bus.MODE  = MODE_WAVE;
        bus.STEPS = '0;
        bus.DIV   = '0;
        #2;
        chk("rst_out", outs(), 4'b0001);
        chk("rst_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("rst_done", {3'b0, bus.DONE}, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // half, fwd, 3 steps, DIV=2 from POS 0
        go(MODE_HALF, 1'b0, 8'd3, 8'd2);
        cyc();
        bus.START = 1'b0;
        chk("h_e0_out", outs(), 4'b0001);
        chk("h_e0_busy", {3'b0, bus.BUSY}, 4'd1);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk($sformatf("h_out%0d", i), outs(), h_out[i]);
            chk($sformatf("h_busy%0d", i), {3'b0, bus.BUSY},
                {3'b0, i < 9});
            chk($sformatf("h_done%0d", i), {3'b0, bus.DONE},
                {3'b0, i == 9});
        end
        cyc();
        chk("h_post_done", {3'b0, bus.DONE}, 4'd0);

        // full fwd from POS 3, then reset mid-move
        go(MODE_FULL, 1'b0, 8'd10, 8'd0);
        cyc();
        bus.START = 1'b0;
        chk("f_align", outs(), 4'b0110);
        cyc();
        chk("f_step1", outs(), 4'b1100);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", outs(), 4'b0001);
        chk("mid_rst_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("mid_rst_done", {3'b0, bus.DONE}, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("rel_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("rel_done", {3'b0, bus.DONE}, 4'd0);
        chk("rel_out", outs(), 4'b0001);

        // full reverse, 2 steps, inputs scrambled during RUN
        go(MODE_FULL, 1'b1, 8'd2, 8'd0);
        cyc();
        bus.START = 1'b0;
        bus.DIR   = 1'b0;
        bus.MODE  = MODE_WAVE;
        bus.STEPS = 8'hff;
        bus.DIV   = 8'h07;
        chk("fr_align", outs(), 4'b0011);
        chk("fr_busy0", {3'b0, bus.BUSY}, 4'd1);
        cyc();
        chk("fr_step1", outs(), 4'b1001);
        chk("fr_done1", {3'b0, bus.DONE}, 4'd0);
        cyc();
        chk("fr_step2", outs(), 4'b1100);
        chk("fr_busy2", {3'b0, bus.BUSY}, 4'd0);
        chk("fr_done2", {3'b0, bus.DONE}, 4'd1);

        // START in the DONE cycle: half fwd one step, POS 5 -> 6
        go(MODE_HALF, 1'b0, 8'd1, 8'd0);
        cyc();
        bus.START = 1'b0;
        chk("b2b_busy", {3'b0, bus.BUSY}, 4'd1);
        chk("b2b_done", {3'b0, bus.DONE}, 4'd0);
        chk("b2b_out", outs(), 4'b1100);
        cyc();
        chk("b2b_step", outs(), 4'b1000);
        chk("b2b_done1", {3'b0, bus.DONE}, 4'd1);

        // wave fwd 5 steps from POS 6 with wrap; START during BUSY
        go(MODE_WAVE, 1'b0, 8'd5, 8'd0);
        cyc();
        bus.STEPS = 8'd0;
        bus.MODE  = MODE_HALF;
        chk("w_align", outs(), 4'b1000);
        chk("w_busy0", {3'b0, bus.BUSY}, 4'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            bus.START = 1'b0;
            chk($sformatf("w_out%0d", i), outs(), w_out[i]);
            chk($sformatf("w_busy%0d", i), {3'b0, bus.BUSY},
                {3'b0, i < 5});
            chk($sformatf("w_done%0d", i), {3'b0, bus.DONE},
                {3'b0, i == 5});
        end
        cyc();
        chk("w_noq_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("w_noq_done", {3'b0, bus.DONE}, 4'd0);

        // abort on a step edge of a 10-step DIV=1 move
        go(MODE_HALF, 1'b0, 8'd10, 8'd1);
        cyc();
        bus.START = 1'b0;
        chk("a_e0", outs(), 4'b0001);
        cyc();
        chk("a_e1", outs(), 4'b0001);
        cyc();
        chk("a_e2", outs(), 4'b0011);
        cyc();
        chk("a_e3_busy", {3'b0, bus.BUSY}, 4'd1);
        bus.ABORT = 1'b1;
        cyc();
        bus.ABORT = 1'b0;
        chk("a_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("a_done", {3'b0, bus.DONE}, 4'd0);
        chk("a_hold", outs(), 4'b0011);
        cyc();
        chk("a_done2", {3'b0, bus.DONE}, 4'd0);
        chk("a_hold2", outs(), 4'b0011);

        // START with ABORT in IDLE is ignored (wave would realign)
        go(MODE_WAVE, 1'b0, 8'd4, 8'd0);
        bus.ABORT = 1'b1;
        cyc();
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        chk("sa_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("sa_done", {3'b0, bus.DONE}, 4'd0);
        chk("sa_out", outs(), 4'b0011);
        cyc();
        chk("sa_busy2", {3'b0, bus.BUSY}, 4'd0);

        // zero-step START: align only, DONE pulse
        go(MODE_WAVE, 1'b0, 8'd0, 8'd0);
        cyc();
        bus.START = 1'b0;
        chk("z_busy", {3'b0, bus.BUSY}, 4'd0);
        chk("z_done", {3'b0, bus.DONE}, 4'd1);
        chk("z_out", outs(), 4'b0001);
        cyc();
        chk("z_done2", {3'b0, bus.DONE}, 4'd0);
        chk("z_out2", outs(), 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
